// File: rtl/icache_controller.sv
//------------------------------------------------------------------------------
// Module      : icache_controller
// Description : Read-only instruction cache controller sitting between the
//               fetch stage, the I_SRAM array and the imem block port.
//               A hit returns the instruction in the request cycle. A miss
//               stalls fetch, reads one block from imem and fills I_SRAM.
//               Optional macro ICACHE_BYPASS_EN forwards the returning imem
//               word straight to fetch in the refill cycle.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module icache_controller #(
  parameter int ADDR_W       = 32,
  parameter int WORD_W       = 32,
  parameter int BLOCK_W      = 128,
  parameter int OFFSET_W     = 4,
  parameter int BLOCK_ADDR_W = ADDR_W - OFFSET_W
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ren,
  input  logic [ADDR_W-1:0]       addr,
  output logic                    stall,
  output logic [WORD_W-1:0]       dout,
  output logic                    cacheRen,
  output logic                    cacheMemWen,
  output logic [BLOCK_ADDR_W-1:0] cacheBlockAddr,
  output logic [BLOCK_W-1:0]      cacheDin,
  input  logic                    cacheHit,
  input  logic [BLOCK_W-1:0]      cacheDout,
  output logic                    imem_ren,
  output logic [BLOCK_ADDR_W-1:0] imem_block_address,
  input  logic                    imem_read_ready,
  input  logic [BLOCK_W-1:0]      imem_dout
);

  localparam int c_WORDS = BLOCK_W / WORD_W;
  localparam int c_SEL_W = OFFSET_W - 2;

  typedef enum logic [0:0] {
    S_LOOKUP  = 1'b0,
    S_MEM_REQ = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [BLOCK_ADDR_W-1:0] r_miss_baddr;
  logic [BLOCK_ADDR_W-1:0] w_next_miss_baddr;

  logic [BLOCK_ADDR_W-1:0] w_req_baddr;
  logic [c_SEL_W-1:0]      w_word_sel;
  logic [WORD_W-1:0]       w_sram_word;
  logic [WORD_W-1:0]       w_imem_word;
  logic                    w_unused;

  assign w_req_baddr = addr[ADDR_W-1:OFFSET_W];
  assign w_word_sel  = addr[OFFSET_W-1:2];
  // Byte lane within the instruction word carries no information here.
  assign w_unused    = ^addr[1:0];

  // Select the addressed instruction out of the SRAM block and the imem block.
  always_comb begin
    w_sram_word = '0;
    w_imem_word = '0;
    for (int i = 0; i < c_WORDS; i++) begin
      if (w_word_sel == i[c_SEL_W-1:0]) begin
        w_sram_word = cacheDout[i*WORD_W +: WORD_W];
        w_imem_word = imem_dout[i*WORD_W +: WORD_W];
      end
    end
  end

  // State and captured miss block address.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_LOOKUP;
      r_miss_baddr <= '0;
    end else begin
      r_state      <= w_next_state;
      r_miss_baddr <= w_next_miss_baddr;
    end
  end

  // Next-state logic and all port outputs; reset forces every strobe low.
  always_comb begin
    w_next_state       = r_state;
    w_next_miss_baddr  = r_miss_baddr;
    stall              = 1'b0;
    dout               = '0;
    cacheRen           = 1'b0;
    cacheMemWen        = 1'b0;
    cacheBlockAddr     = w_req_baddr;
    cacheDin           = imem_dout;
    imem_ren           = 1'b0;
    imem_block_address = r_miss_baddr;

    if (!reset) begin
      case (r_state)
        S_LOOKUP: begin
          cacheRen = ren;
          if (ren) begin
            if (cacheHit) begin
              dout = w_sram_word;
            end else begin
              stall             = 1'b1;
              w_next_miss_baddr = w_req_baddr;
              w_next_state      = S_MEM_REQ;
            end
          end
        end

        S_MEM_REQ: begin
          stall    = 1'b1;
          imem_ren = 1'b1;
          if (imem_read_ready) begin
            cacheMemWen    = 1'b1;
            cacheBlockAddr = r_miss_baddr;
            w_next_state   = S_LOOKUP;
`ifdef ICACHE_BYPASS_EN
            // Forward the word only if fetch still wants the refilled block.
            if (ren && (w_req_baddr == r_miss_baddr)) begin
              stall = 1'b0;
              dout  = w_imem_word;
            end
`endif
          end
        end

        default: begin
          w_next_state = S_LOOKUP;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_icache_controller.sv
//------------------------------------------------------------------------------
// Module      : tb_icache_controller
// Description : Self-checking bench for icache_controller with an I_SRAM
//               model, an imem responder and a fetch-level reference model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_icache_controller;

`ifdef ICACHE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clock;
  logic         reset;
  logic         ren;
  logic [31:0]  addr;
  logic         stall;
  logic [31:0]  dout;
  logic         cacheRen;
  logic         cacheMemWen;
  logic [27:0]  cacheBlockAddr;
  logic [127:0] cacheDin;
  logic         cacheHit;
  logic [127:0] cacheDout;
  logic         imem_ren;
  logic [27:0]  imem_block_address;
  logic         imem_read_ready;
  logic [127:0] imem_dout;

  int checks   = 0;
  int failures = 0;

  icache_controller dut (
    .clock              (clock),
    .reset              (reset),
    .ren                (ren),
    .addr               (addr),
    .stall              (stall),
    .dout               (dout),
    .cacheRen           (cacheRen),
    .cacheMemWen        (cacheMemWen),
    .cacheBlockAddr     (cacheBlockAddr),
    .cacheDin           (cacheDin),
    .cacheHit           (cacheHit),
    .cacheDout          (cacheDout),
    .imem_ren           (imem_ren),
    .imem_block_address (imem_block_address),
    .imem_read_ready    (imem_read_ready),
    .imem_dout          (imem_dout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory contents: block 0x10 carries the directed pattern, others a hash.
  function automatic logic [127:0] block_data(input logic [27:0] b);
    logic [127:0] d;
    if (b == 28'h10) d = {32'h44, 32'h33, 32'h22, 32'h11};
    else for (int k = 0; k < 4; k++) d[32*k +: 32] = {b, 4'(k*4)} ^ 32'h5A5A_0000;
    return d;
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    logic [127:0] d;
    int k;
    d = block_data(a[31:4]);
    k = int'(a[3:2]);
    return d[32*k +: 32];
  endfunction

  // I_SRAM model: direct mapped, 64 sets, full block address kept as tag.
  bit           sv    [64];
  logic [27:0]  stag  [64];
  logic [127:0] sdata [64];
  int           n_fill = 0;
  logic [27:0]  fill_addr = '0;

  assign cacheHit  = cacheRen && sv[cacheBlockAddr[5:0]] && (stag[cacheBlockAddr[5:0]] == cacheBlockAddr);
  assign cacheDout = sdata[cacheBlockAddr[5:0]];

  // SRAM write port and fill bookkeeping.
  always @(posedge clock) begin
    if (cacheMemWen) begin
      sv[cacheBlockAddr[5:0]]    <= 1'b1;
      stag[cacheBlockAddr[5:0]]  <= cacheBlockAddr;
      sdata[cacheBlockAddr[5:0]] <= cacheDin;
      n_fill                     <= n_fill + 1;
      fill_addr                  <= cacheBlockAddr;
    end
  end

  // imem responder: ready pulses in the mem_lat-th cycle of imem_ren.
  bit          auto_mem   = 1'b1;
  bit          man_ready  = 1'b0;
  int          mem_lat    = 3;
  int          cnt        = 0;
  bit          prev_ren   = 1'b0;
  int          n_req      = 0;
  logic [27:0] req_addr   = '0;
  bit          unstable   = 1'b0;

  initial begin
    imem_read_ready = 1'b0;
    imem_dout       = '0;
  end

  always @(negedge clock) begin
    prev_ren  <= imem_ren;
    imem_dout <= block_data(imem_block_address);
    if (imem_ren) begin
      if (!prev_ren) begin
        n_req    <= n_req + 1;
        req_addr <= imem_block_address;
        cnt      <= 1;
        imem_read_ready <= auto_mem ? (mem_lat == 1) : man_ready;
      end else begin
        if (imem_block_address != req_addr) unstable <= 1'b1;
        cnt <= cnt + 1;
        imem_read_ready <= auto_mem ? (cnt + 1 == mem_lat) : man_ready;
      end
    end else begin
      cnt <= 0;
      imem_read_ready <= auto_mem ? 1'b0 : man_ready;
    end
  end

  // Reference: which block each set is known to hold after completed fetches.
  bit          ref_v   [64];
  logic [27:0] ref_blk [64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One fetch from request to delivery; called just after a rising edge.
  task automatic fetch(input logic [31:0] a, input int lat);
    int          stalls;
    int          f0;
    int          r0;
    bit          hit;
    bit          done;
    logic [27:0] b;
    b   = a[31:4];
    hit = ref_v[b[5:0]] && (ref_blk[b[5:0]] == b);
    mem_lat = lat;
    f0 = n_fill;
    r0 = n_req;
    ren  = 1'b1;
    addr = a;
    stalls = 0;
    done   = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clock); #1;
      if (!stall) done = 1'b1;
      else begin
        stalls++;
        @(posedge clock); #1;
      end
    end
    chk("stall_cycles", stalls, hit ? 0 : (BYP ? lat : lat + 1));
    chk("dout", dout, exp_word(a));
    if (hit) begin
      chk("hit_imem_ren", {31'b0, imem_ren}, 32'd0);
      chk("hit_no_fill_strobe", {31'b0, cacheMemWen}, 32'd0);
    end
    @(posedge clock); #1;
    chk("fill_count", n_fill - f0, hit ? 0 : 1);
    chk("req_count", n_req - r0, hit ? 0 : 1);
    if (!hit) begin
      chk("req_block", {4'b0, req_addr}, {4'b0, b});
      chk("fill_block", {4'b0, fill_addr}, {4'b0, b});
      ref_v[b[5:0]]   = 1'b1;
      ref_blk[b[5:0]] = b;
    end
  endtask

  initial begin
    int          f0;
    bit          seen;
    int          r;
    logic [27:0] pb;
    logic [31:0] a;

    // Reset state with a live request on the inputs.
    reset = 1'b1;
    ren   = 1'b1;
    addr  = 32'h100;
    @(posedge clock); @(posedge clock);
    @(negedge clock); #1;
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_cacheRen", {31'b0, cacheRen}, 32'd0);
    chk("rst_cacheMemWen", {31'b0, cacheMemWen}, 32'd0);
    chk("rst_imem_ren", {31'b0, imem_ren}, 32'd0);
    chk("rst_dout", dout, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Cold miss, hits in the same block, back-to-back hit then miss.
    fetch(32'h100, 3);
    fetch(32'h10C, 3);
    fetch(32'h104, 3);
    fetch(32'h200, 2);

    // Fetch drops ren mid-miss: the refill still completes.
    mem_lat = 3;
    f0   = n_fill;
    ren  = 1'b1;
    addr = 32'h300;
    @(negedge clock); #1;
    chk("drop_miss_stall", {31'b0, stall}, 32'd1);
    @(posedge clock); #1;
    ren  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock); #1;
      if (imem_read_ready) begin
        seen = 1'b1;
        chk("drop_fill_strobe", {31'b0, cacheMemWen}, 32'd1);
        chk("drop_ready_stall", {31'b0, stall}, 32'd1);
      end else begin
        @(posedge clock); #1;
      end
    end
    chk("drop_ready_seen", {31'b0, seen}, 32'd1);
    @(posedge clock); #1;
    chk("drop_fill_count", n_fill - f0, 32'd1);
    chk("drop_fill_block", {4'b0, fill_addr}, 32'h30);
    ref_v[6'h30]   = 1'b1;
    ref_blk[6'h30] = 28'h30;
    fetch(32'h304, 3);

    // Reset one cycle into a miss; a late ready pulse must not fill.
    auto_mem  = 1'b0;
    man_ready = 1'b0;
    f0   = n_fill;
    ren  = 1'b1;
    addr = 32'h400;
    @(negedge clock); #1;
    chk("rstmiss_stall", {31'b0, stall}, 32'd1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock); #1;
    chk("rstmiss_imem_ren_in_rst", {31'b0, imem_ren}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    ren   = 1'b0;
    @(negedge clock); #1;
    chk("rstmiss_imem_ren_after", {31'b0, imem_ren}, 32'd0);
    @(posedge clock); #1;
    man_ready = 1'b1;
    @(negedge clock); #1;
    chk("rstmiss_late_ready_seen", {31'b0, imem_read_ready}, 32'd1);
    chk("rstmiss_no_fill", {31'b0, cacheMemWen}, 32'd0);
    chk("rstmiss_stall_low", {31'b0, stall}, 32'd0);
    @(posedge clock); #1;
    man_ready = 1'b0;
    auto_mem  = 1'b1;
    chk("rstmiss_fill_count", n_fill - f0, 32'd0);
    fetch(32'h400, 2);

    // Address moves to another (resident) block before ready arrives.
    mem_lat = 3;
    f0   = n_fill;
    ren  = 1'b1;
    addr = 32'h580;
    @(negedge clock); #1;
    chk("chg_miss_stall", {31'b0, stall}, 32'd1);
    @(posedge clock); #1;
    addr = 32'h208;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock); #1;
      if (imem_read_ready) begin
        seen = 1'b1;
        chk("chg_ready_stall", {31'b0, stall}, 32'd1);
        chk("chg_fill_strobe", {31'b0, cacheMemWen}, 32'd1);
      end else begin
        @(posedge clock); #1;
      end
    end
    chk("chg_ready_seen", {31'b0, seen}, 32'd1);
    @(posedge clock); #1;
    chk("chg_fill_count", n_fill - f0, 32'd1);
    chk("chg_fill_block", {4'b0, fill_addr}, 32'h58);
    ref_v[6'h18]   = 1'b1;
    ref_blk[6'h18] = 28'h58;
    @(negedge clock); #1;
    chk("chg_next_hit_stall", {31'b0, stall}, 32'd0);
    chk("chg_next_hit_dout", dout, exp_word(32'h208));
    @(posedge clock); #1;

    // Random fetch stream over a small block pool with set conflicts.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        ren  = 1'b0;
        addr = $urandom;
        @(negedge clock); #1;
        chk("idle_stall", {31'b0, stall}, 32'd0);
        chk("idle_cacheRen", {31'b0, cacheRen}, 32'd0);
        chk("idle_imem_ren", {31'b0, imem_ren}, 32'd0);
        @(posedge clock); #1;
      end
      r  = $urandom_range(0, 11);
      pb = (r < 8) ? (28'h10 + 28'(r)) : (28'h50 + 28'(r - 8));
      a  = {pb, 2'($urandom), 2'($urandom)};
      fetch(a, $urandom_range(1, 4));
    end

    chk("imem_addr_stable", {31'b0, unstable}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
